fetch_stage: RTL



---
 rtl/fetch_stage.sv | 81 ++++++++
 1 files changed

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - F-stage PC, instruction fetch and F/D pipeline register
// Delay-slot redirects; variable-latency memory; hazard stalls.
module fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        im_req,
   output logic [31:0] im_addr,
   input  logic        im_ready,
   input  logic [31:0] im_rdata,
   output logic [31:0] PC_F,
   output logic [31:0] PC_D,
   output logic [31:0] inStr_D,
   output logic        valid_D
);

   typedef enum logic {FETCH, HOLD} state_t;

   state_t      state;
   logic        pending;
   logic [31:0] pend_pc;
   logic [31:0] buffer;

   logic        have_instr;
   logic [31:0] instr_word;
   logic [31:0] redir_tgt;
   logic [31:0] next_pc;

   always_comb begin
      im_req     = (state == FETCH) && !reset;
      im_addr    = PC_F;
      have_instr = (state == HOLD) || im_ready;
      instr_word = (state == HOLD) ? buffer : im_rdata;
      redir_tgt  = redirect_pc & ~32'h0000_0003;
      // A fresh redirect beats an older pending one (last-wins).
      if (redirect_valid)
         next_pc = redir_tgt;
      else if (pending)
         next_pc = pend_pc;
      else
         next_pc = PC_F + 32'd4;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= FETCH;
         PC_F    <= RESET_PC;
         PC_D    <= 32'd0;
         inStr_D <= 32'd0;
         valid_D <= 1'b0;
         pending <= 1'b0;
         pend_pc <= 32'd0;
         buffer  <= 32'd0;
      end else if (!stall) begin
         PC_D <= PC_F;
         if (have_instr) begin
            inStr_D <= instr_word;
            valid_D <= 1'b1;
            PC_F    <= next_pc;
            pending <= 1'b0;
            state   <= FETCH;
         end else begin
            inStr_D <= 32'd0;
            valid_D <= 1'b0;
            if (redirect_valid) begin
               pending <= 1'b1;
               pend_pc <= redir_tgt;
            end
         end
      end else if (state == FETCH && im_ready) begin
         // Response arrived under stall: park it so no re-fetch is needed.
         buffer <= im_rdata;
         state  <= HOLD;
      end
   end

endmodule
